// File: rtl/oam_dma_ctrl.sv
// Sprite-RAM DMA sequencer: on a CPU write to the trigger address it stalls the CPU and
// copies XFER_LEN bytes from page {data,00h} into the OAM data port; otherwise it passes the bus through.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_wen,
  input  logic        cpu_ren,
  output logic [7:0]  cpu_data_in,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_wen,
  output logic        mem_ren,
  input  logic [7:0]  mem_data_in,
  output logic        dma_busy,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_e;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_e     state_q, state_d;
  logic       parity_q, parity_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q, page_d;
  logic [7:0] buffer_q, buffer_d;
  logic       done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      parity_q <= 1'b0;
      idx_q    <= 8'h00;
      page_q   <= 8'h00;
      buffer_q <= 8'h00;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= parity_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      buffer_q <= buffer_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    parity_d     = ~parity_q;
    idx_d        = idx_q;
    page_d       = page_q;
    buffer_d     = buffer_q;
    done_d       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_out = 8'h00;
    mem_wen      = 1'b0;
    mem_ren      = 1'b0;
    cpu_data_in  = 8'h00;

    case (state_q)
      S_IDLE: begin
        // The trigger write itself still reaches memory like any other CPU write.
        mem_addr     = cpu_addr;
        mem_data_out = cpu_data_out;
        mem_wen      = cpu_wen;
        mem_ren      = cpu_ren;
        cpu_data_in  = mem_data_in;
        if (cpu_wen && (cpu_addr == DMA_TRIG_ADDR)) begin
          page_d  = cpu_data_out;
          idx_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // An odd HALT means the next cycle is even, so reads can start right away.
        state_d = parity_q ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_d = S_READ;
      end
      S_READ: begin
        mem_ren  = 1'b1;
        mem_addr = {page_q, idx_q};
        buffer_d = mem_data_in;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        mem_wen      = 1'b1;
        mem_addr     = OAM_DATA_ADDR;
        mem_data_out = buffer_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign cpu_stall = (state_q != S_IDLE);
  assign dma_busy  = (state_q != S_IDLE);
  assign dma_done  = done_q;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Scoreboard bench for oam_dma_ctrl: stimulus queues expected bus cycles, a monitor
// compares every enabled memory cycle against them; a tiny ROM/RAM function models memory.
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_wen = 1'b0;
  logic        cpu_ren = 1'b0;
  logic [7:0]  cpu_data_in;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_wen;
  logic        mem_ren;
  logic [7:0]  mem_data_in;
  logic        dma_busy;
  logic        dma_done;

  typedef struct packed {
    logic        wen;
    logic        ren;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic tb_par = 1'b0;

  oam_dma_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_wen      (cpu_wen),
    .cpu_ren      (cpu_ren),
    .cpu_data_in  (cpu_data_in),
    .cpu_stall    (cpu_stall),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_data_in  (mem_data_in),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done)
  );

  // Page 02h holds the index pattern, page FFh an inverted ROM pattern, everything else a hash.
  function automatic logic [7:0] memval(input logic [15:0] a);
    if (a[15:8] == 8'h02)      return a[7:0];
    else if (a[15:8] == 8'hFF) return (~a[7:0]) ^ 8'h3C;
    else                       return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign mem_data_in = memval(mem_addr);

  always #5 clk = ~clk;

  // Reference cycle parity, reset alongside the DUT.
  always @(posedge clk) tb_par <= rst ? 1'b0 : ~tb_par;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every enabled bus cycle must match the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst && (mem_wen || mem_ren)) begin
      checkOutput("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        txn_t e;
        e = exp_q.pop_front();
        checkOutput("bus_kind", {30'd0, mem_wen, mem_ren}, {30'd0, e.wen, e.ren});
        checkOutput("bus_addr", 32'(mem_addr), 32'(e.addr));
        if (e.wen) checkOutput("bus_wdata", 32'(mem_data_out), 32'(e.data));
      end
      if (dma_busy) checkOutput("dma_parity", 32'(tb_par), 32'(mem_wen));
    end
  end

  task automatic applyStimulus(input logic [7:0] page, input logic want_par,
                               input int n_exp, input bit hold_retrig);
    @(posedge clk); #1;
    if (tb_par != want_par) begin
      @(posedge clk); #1;
    end
    exp_q.push_back('{1'b1, 1'b0, 16'h4014, page});
    for (int i = 0; i < n_exp; i++) begin
      logic [7:0]  b;
      logic [15:0] src;
      b   = 8'(i);
      src = {page, b};
      exp_q.push_back('{1'b0, 1'b1, src, 8'h00});
      exp_q.push_back('{1'b1, 1'b0, 16'h2004, memval(src)});
    end
    cpu_addr     = 16'h4014;
    cpu_data_out = page;
    cpu_wen      = 1'b1;
    cpu_ren      = 1'b0;
    @(posedge clk); #1;
    if (hold_retrig) cpu_data_out = 8'h05;
    else begin
      cpu_wen      = 1'b0;
      cpu_addr     = 16'h0000;
      cpu_data_out = 8'h00;
    end
  endtask

  task automatic runStall(input int expect_len, input bit hold_retrig);
    int cnt = 0;
    int done_cnt = 0;
    bit ended = 0;
    for (int c = 0; c < 700 && !ended; c++) begin
      @(negedge clk);
      if (!cpu_stall) ended = 1;
      else begin
        cnt++;
        if (dma_done) done_cnt++;
        if (cnt == 50) checkOutput("cpu_data_in_masked", 32'(cpu_data_in), 32'd0);
        @(posedge clk); #1;
        if (hold_retrig && cnt == 100) begin
          cpu_wen      = 1'b0;
          cpu_addr     = 16'h0000;
          cpu_data_out = 8'h00;
        end
      end
    end
    checkOutput("stall_len", 32'(cnt), 32'(expect_len));
    checkOutput("done_during_stall", 32'(done_cnt), 32'd0);
    checkOutput("done_at_stall_end", 32'(dma_done), 32'd1);
    @(negedge clk); #1;
    checkOutput("done_single_pulse", 32'(dma_done), 32'd0);
    checkOutput("busy_after", 32'(dma_busy), 32'd0);
    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit found;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("rst_busy", 32'(dma_busy), 32'd0);
    checkOutput("rst_done", 32'(dma_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Pass-through read and write while idle.
    @(posedge clk); #1;
    exp_q.push_back('{1'b0, 1'b1, 16'h0010, 8'h00});
    cpu_addr = 16'h0010;
    cpu_ren  = 1'b1;
    @(negedge clk);
    checkOutput("pt_rd_ren", 32'(mem_ren), 32'd1);
    checkOutput("pt_rd_addr", 32'(mem_addr), 32'h0010);
    checkOutput("pt_rd_data", 32'(cpu_data_in), 32'h4A);
    checkOutput("pt_busy", 32'(dma_busy), 32'd0);
    checkOutput("pt_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    exp_q.push_back('{1'b1, 1'b0, 16'h6000, 8'h55});
    cpu_ren      = 1'b0;
    cpu_wen      = 1'b1;
    cpu_addr     = 16'h6000;
    cpu_data_out = 8'h55;
    @(negedge clk);
    checkOutput("pt_wr_wen", 32'(mem_wen), 32'd1);
    checkOutput("pt_wr_addr", 32'(mem_addr), 32'h6000);
    checkOutput("pt_wr_data", 32'(mem_data_out), 32'h55);
    checkOutput("pt_wr_ren", 32'(mem_ren), 32'd0);
    @(posedge clk); #1;
    cpu_wen      = 1'b0;
    cpu_addr     = 16'h0000;
    cpu_data_out = 8'h00;

    $display("[TB] transfer page 02h, even trigger");
    applyStimulus(8'h02, 1'b0, 256, 1'b0);
    runStall(513, 1'b0);

    $display("[TB] transfer page 02h, odd trigger");
    applyStimulus(8'h02, 1'b1, 256, 1'b0);
    runStall(514, 1'b0);

    $display("[TB] transfer page FFh");
    applyStimulus(8'hFF, 1'b0, 256, 1'b0);
    runStall(513, 1'b0);

    $display("[TB] reset during WRITE of idx 10");
    applyStimulus(8'h03, 1'b0, 11, 1'b0);
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (mem_wen && mem_addr == 16'h2004 && mem_data_out == memval(16'h030A)) found = 1;
    end
    checkOutput("rst_wait_found", 32'(found), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_stall", 32'(cpu_stall), 32'd0);
    checkOutput("midrst_busy", 32'(dma_busy), 32'd0);
    checkOutput("midrst_done", 32'(dma_done), 32'd0);
    checkOutput("midrst_wen", 32'(mem_wen), 32'd0);
    checkOutput("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(8'h04, 1'b1, 256, 1'b0);
    runStall(514, 1'b0);

    $display("[TB] retrigger attempt held during stall");
    applyStimulus(8'h02, 1'b0, 256, 1'b1);
    runStall(513, 1'b1);

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("final_idle", 32'(dma_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite-RAM DMA sequencer and bus arbiter between the CPU and the shared memory bus.
- Detects a CPU write to 4014h, stalls the CPU, then copies 256 bytes from page {data,00h} into the SPR-RAM data register at 2004h.
- Each byte is moved as one read cycle followed by one write cycle.
- Outside a transfer it is a transparent pass-through between the CPU and the memory decoder.

Parameters:
- DMA_TRIG_ADDR, 16'h4014, CPU write address that starts a transfer.
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
- XFER_LEN, 256, bytes per transfer; a power of two, 2..256. Source offset is idx[7:0].

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_addr  in  16  CPU address
- cpu_data_out  in  8  CPU write data
- cpu_wen  in  1  CPU write enable
- cpu_ren  in  1  CPU read enable
- cpu_data_in  out  8  read data returned to the CPU
- cpu_stall  out  1  CPU must hold its state while this is high
- mem_addr  out  16  address to the memory decoder
- mem_data_out  out  8  write data to the memory decoder
- mem_wen  out  1  memory write enable
- mem_ren  out  1  memory read enable
- mem_data_in  in  8  memory read data, combinational, valid in the same cycle as mem_ren
- dma_busy  out  1  high when state != IDLE
- dma_done  out  1  one-cycle pulse when a transfer completes

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset state: state=IDLE, parity=0, idx=0, page=0, buffer=0, dma_done=0, cpu_stall=0, dma_busy=0.
- parity toggles every clk and is forced to 0 by rst.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE (pass-through):
  - mem_addr, mem_data_out, mem_wen and mem_ren follow the CPU signals combinationally.
  - cpu_data_in = mem_data_in.
  - If cpu_wen=1 and cpu_addr=DMA_TRIG_ADDR: the write still passes through to memory; page<=cpu_data_out; idx<=0; next state is HALT.
- HALT: one dead cycle with mem_ren=0 and mem_wen=0. Next state is READ if the next cycle has parity=0, otherwise ALIGN.
- ALIGN: one dead cycle with the bus idle. Next state is READ.
- READ: mem_ren=1, mem_addr={page,idx[7:0]}; buffer<=mem_data_in at the clk edge. Next state is WRITE.
- WRITE: mem_wen=1, mem_addr=OAM_DATA_ADDR, mem_data_out=buffer.
  - If idx=XFER_LEN-1: next state is IDLE and dma_done is high for the following cycle.
  - Otherwise: idx<=idx+1 and next state is READ.
- While state != IDLE:
  - cpu_stall=1 combinationally.
  - CPU ren/wen are masked from memory; cpu_data_in=0.
  - A 4014h write from the CPU is ignored (no retrigger).
- Stall length, trigger cycle excluded: 1 + align + 2*XFER_LEN = 513 or 514 cycles for 256 bytes. align=1 when the cycle after HALT has odd parity.
- READ always falls on a parity=0 cycle and WRITE on a parity=1 cycle.
- Source addressing: page=FFh reads FF00h..FFFFh. idx never carries into the page byte.
- Writes go only to OAM_DATA_ADDR. The controller never writes ROM space; source reads from any region are allowed.
- Reset mid-transfer: next cycle returns to IDLE with cpu_stall=0 and no dma_done pulse. The partial copy is not resumed.
- cpu_stall is de-asserted in the same cycle dma_done is asserted. CPU pass-through resumes that cycle.

Test Plan:
- Trigger on an even cycle: CPU writes 02h to 4014h with RAM 0200h..02FFh = index pattern -> 256 writes to 2004h with data 00h..FFh in order; cpu_stall high for 513 cycles; single dma_done pulse.
- Trigger on an odd cycle: same stimulus one cycle later -> ALIGN visited, stall = 514 cycles; every READ on parity=0.
- Page FFh: trigger with FFh (ROM) -> reads FF00h..FFFFh; last READ addr=FFFFh; no read at 0000h.
- Reset at WRITE of idx=10 -> next cycle state IDLE, cpu_stall=0, dma_done=0; new trigger restarts at idx=0 with page from the new write.
- Retrigger and masking: CPU holds wen=1 at 4014h with data 05h during stall -> no restart, page stays 02h; no CPU-originated mem_wen seen during stall.
- Pass-through: CPU read of 0010h and write 55h to 6000h in IDLE -> mem_* mirror the CPU same cycle; cpu_data_in = mem_data_in; dma_busy=0.
